// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the core memory stage and the RAM data side.
// Handles byte enables, lane replication, load extraction/extension and access faults.
module lsu_ctrl #(
    parameter int unsigned MEM_WORDS = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [29:0] ram_r_addr,
    input  logic [31:0] ram_r_val,
    output logic        ram_w_enable,
    output logic [29:0] ram_w_addr,
    output logic [31:0] ram_w_val,
    output logic [3:0]  ram_byte_en
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_WRITE   = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        w_enable_q, w_enable_d;
    logic [3:0]  byte_en_q, byte_en_d;
    logic [31:0] w_val_q, w_val_d;

    logic        accept_s;
    logic        fault_s;
    logic [31:0] lane_s;
    logic [31:0] load_ext_s;

    // Illegal size encoding, misalignment or word address beyond the RAM.
    function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic illegal;
        logic misaligned;
        logic out_of_range;
        illegal      = we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
        misaligned   = ((f3[1:0] == 2'd1) && a[0]) || ((f3[1:0] == 2'd2) && (a[1:0] != 2'd0));
        out_of_range = (a[31:2] >= 30'(MEM_WORDS));
        return illegal || misaligned || out_of_range;
    endfunction

    assign accept_s = req_valid && req_ready_q;
    assign fault_s  = is_fault(req_we, req_funct3, req_addr);
    assign lane_s   = ram_r_val >> {addr_q[1:0], 3'b000};

    // Load lane extension by latched funct3.
    always_comb begin
        load_ext_s = 32'd0;
        case (funct3_q)
            3'd0:    load_ext_s = {{24{lane_s[7]}}, lane_s[7:0]};
            3'd1:    load_ext_s = {{16{lane_s[15]}}, lane_s[15:0]};
            3'd2:    load_ext_s = lane_s;
            3'd4:    load_ext_s = {24'd0, lane_s[7:0]};
            3'd5:    load_ext_s = {16'd0, lane_s[15:0]};
            default: load_ext_s = 32'd0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'd0;
            funct3_q    <= 3'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            w_enable_q  <= 1'b0;
            byte_en_q   <= 4'd0;
            w_val_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            w_enable_q  <= w_enable_d;
            byte_en_q   <= byte_en_d;
            w_val_q     <= w_val_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!accept_s) begin
                    state_d = S_IDLE;
                end else if (fault_s) begin
                    state_d = S_RESP;
                end else if (req_we) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_RESP;
            S_WRITE:   state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; outputs are set up one edge ahead of their state.
    always_comb begin
        addr_d      = accept_s ? req_addr : addr_q;
        funct3_d    = accept_s ? req_funct3 : funct3_q;
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        rsp_err_d   = (state_q == S_IDLE) && (state_d == S_RESP);
        rsp_rdata_d = (state_q == S_CAPTURE) ? load_ext_s : 32'd0;
        w_enable_d  = (state_d == S_WRITE);
        byte_en_d   = 4'd0;
        w_val_d     = 32'd0;
        if (state_d == S_WRITE) begin
            case (req_funct3[1:0])
                2'd0: begin
                    byte_en_d = 4'b0001 << req_addr[1:0];
                    w_val_d   = {4{req_wdata[7:0]}};
                end
                2'd1: begin
                    byte_en_d = 4'b0011 << req_addr[1:0];
                    w_val_d   = {2{req_wdata[15:0]}};
                end
                2'd2: begin
                    byte_en_d = 4'b1111;
                    w_val_d   = req_wdata;
                end
                default: begin
                    byte_en_d = 4'd0;
                    w_val_d   = 32'd0;
                end
            endcase
        end else begin
            byte_en_d = 4'd0;
            w_val_d   = 32'd0;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign ram_r_addr   = addr_q[31:2];
    assign ram_w_addr   = addr_q[31:2];
    assign ram_w_enable = w_enable_q;
    assign ram_byte_en  = byte_en_q;
    assign ram_w_val    = w_val_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a driver queues expected responses and RAM writes,
// independent monitors compare them against what the controller presents.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [29:0] ram_r_addr;
    logic [31:0] ram_r_val = 32'd0;
    logic        ram_w_enable;
    logic [29:0] ram_w_addr;
    logic [31:0] ram_w_val;
    logic [3:0]  ram_byte_en;

    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_WORDS(500)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_r_addr(ram_r_addr), .ram_r_val(ram_r_val),
        .ram_w_enable(ram_w_enable), .ram_w_addr(ram_w_addr),
        .ram_w_val(ram_w_val), .ram_byte_en(ram_byte_en)
    );

    // RAM model: synchronous read, writes any lane whose byte enable is set.
    logic [31:0] mem [0:511] = '{default: 32'h0};
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_byte_en[b]) mem[ram_w_addr[8:0]][8*b +: 8] <= ram_w_val[8*b +: 8];
        end
        ram_r_val <= mem[ram_r_addr[8:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic err; logic [31:0] data; int cyc; string nm; } rsp_t;
    typedef struct { logic [29:0] a; logic [3:0] be; logic [31:0] v; int cyc; string nm; } wr_t;
    rsp_t rq[$];
    wr_t  wq[$];

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response and write monitors.
    always @(negedge clk) begin : mon
        rsp_t e;
        wr_t  w;
        if (rst_n) begin
            if (rsp_valid) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got err=%b data=%h expected no response", rsp_err, rsp_rdata);
                end else begin
                    e = rq.pop_front();
                    chk({e.nm, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
                    chk({e.nm, "_rdata"}, rsp_rdata, e.data);
                    chk({e.nm, "_cycle"}, cyc, e.cyc);
                end
            end
            if (ram_w_enable) begin
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr=%h be=%b expected no write", ram_w_addr, ram_byte_en);
                end else begin
                    w = wq.pop_front();
                    chk({w.nm, "_waddr"}, {2'b00, ram_w_addr}, {2'b00, w.a});
                    chk({w.nm, "_be"}, {28'd0, ram_byte_en}, {28'd0, w.be});
                    chk({w.nm, "_wval"}, ram_w_val, w.v);
                    chk({w.nm, "_wcycle"}, cyc, w.cyc);
                end
            end else begin
                chk("byte_en_idle", {28'd0, ram_byte_en}, 32'd0);
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic push, input logic ex_err,
                         input logic [31:0] ex_data, input logic [3:0] ex_be,
                         input logic [31:0] ex_wv, input string nm);
        int waitc = 0;
        int lat;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL %s_ready: got req_ready=0 expected 1 within 20 cycles", nm);
            req_valid = 1'b0;
            return;
        end
        if (push) begin
            lat = ex_err ? 1 : (we ? 2 : 3);
            rq.push_back('{ex_err, ex_data, cyc + lat, nm});
            if (we && !ex_err) wq.push_back('{a[31:2], ex_be, ex_wv, cyc + 1, nm});
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] wv, input string nm);
        issue(1'b1, f3, a, wd, 1'b1, 1'b0, 32'd0, be, wv, nm);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input string nm);
        issue(1'b0, f3, a, 32'd0, 1'b1, 1'b0, d, 4'd0, 32'd0, nm);
    endtask

    task automatic flt(input logic we, input logic [2:0] f3, input logic [31:0] a, input string nm);
        issue(we, f3, a, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 4'd0, 32'd0, nm);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
        chk({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({nm, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({nm, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({nm, "_r_addr"}, {2'b00, ram_r_addr}, 32'd0);
        chk({nm, "_w_addr"}, {2'b00, ram_w_addr}, 32'd0);
        chk({nm, "_w_en"}, {31'd0, ram_w_enable}, 32'd0);
        chk({nm, "_w_val"}, ram_w_val, 32'd0);
        chk({nm, "_be"}, {28'd0, ram_byte_en}, 32'd0);
    endtask

    initial begin
        int w;
        #12;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        st(3'd2, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, "sw_10");
        st(3'd0, 32'h13, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, "sb_13");
        ld(3'd0, 32'h13, 32'hFFFF_FFA5, "lb_13");
        ld(3'd4, 32'h13, 32'h0000_00A5, "lbu_13");
        ld(3'd2, 32'h10, 32'hA5AD_BEEF, "lw_10_merged");

        st(3'd2, 32'h10, 32'h8001_0000, 4'b1111, 32'h8001_0000, "sw_10b");
        ld(3'd1, 32'h12, 32'hFFFF_8001, "lh_12");
        ld(3'd5, 32'h12, 32'h0000_8001, "lhu_12");
        flt(1'b0, 3'd2, 32'h12, "lw_12_misaligned");

        st(3'd1, 32'h16, 32'hFFFF_1234, 4'b1100, 32'h1234_1234, "sh_16");
        st(3'd0, 32'h15, 32'h0000_007F, 4'b0010, 32'h7F7F_7F7F, "sb_15");
        ld(3'd0, 32'h15, 32'h0000_007F, "lb_15_pos");
        ld(3'd1, 32'h14, 32'h0000_7F00, "lh_14");
        ld(3'd2, 32'h14, 32'h1234_7F00, "lw_14");
        ld(3'd4, 32'h17, 32'h0000_0012, "lbu_17");
        ld(3'd0, 32'h16, 32'h0000_0034, "lb_16");

        st(3'd2, 32'h7CC, 32'h5A5A_0001, 4'b1111, 32'h5A5A_0001, "sw_last_word");
        ld(3'd2, 32'h7CC, 32'h5A5A_0001, "lw_last_word");

        flt(1'b0, 3'd2, 32'h6, "lw_6");
        flt(1'b1, 3'd1, 32'h3, "sh_3");
        flt(1'b0, 3'd3, 32'h0, "ld_f3_3");
        flt(1'b1, 3'd2, 32'h7D0, "sw_word500");
        flt(1'b1, 3'd3, 32'h0, "st_f3_3");
        flt(1'b0, 3'd6, 32'h8, "ld_f3_6");
        flt(1'b0, 3'd7, 32'h8, "ld_f3_7");
        flt(1'b0, 3'd5, 32'h1, "lhu_1");
        flt(1'b0, 3'd0, 32'h7D0, "lb_word500");
        flt(1'b1, 3'd0, 32'hFFFF_FFFF, "sb_top");

        // Store aborted by reset while in WRITE.
        st(3'd2, 32'h20, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, "sw_20");
        issue(1'b1, 3'd2, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, "sw_20_abort");
        chk("abort_in_write", {31'd0, ram_w_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_be", {28'd0, ram_byte_en}, 32'd0);
        chk("abort_wen", {31'd0, ram_w_enable}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_mem", mem[8], 32'hCAFE_F00D);
        ld(3'd2, 32'h20, 32'hCAFE_F00D, "lw_20_after_abort");

        w = 0;
        while ((rq.size() != 0 || wq.size() != 0) && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (rq.size() != 0 || wq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d responses and %0d writes pending expected 0", rq.size(), wq.size());
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
